// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Instruction-side responder for a single-cycle MIPS32 core. After reset it
//   accepts a byte-serial program image over a valid/ready stream and packs it
//   little-endian into 32-bit words in a local instruction RAM. Once the final
//   byte (in_last) is accepted it raises run and serves instructions
//   combinationally; any address outside the loaded image reads as NOP (0).
//
//   Optional feature: define IMEM_CHECKSUM_EN to get a running 32-bit sum of
//   all committed words on checksum; otherwise checksum is tied to zero.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    loader byte valid
//   in_data     loader byte
//   in_last     final byte of the image (qualified by in_valid)
//   in_ready    byte can be accepted this cycle (high while loading)
//   raddr       word address from the core
//   instr       instruction word for raddr (zero-latency read)
//   run         image loaded, core may advance
//   word_count  number of words committed
//   overflow    sticky: bytes arrived after the RAM filled
//   checksum    running sum of committed words (IMEM_CHECKSUM_EN only)
module imem_stream_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [31:0]           raddr,
  output logic [31:0]           instr,
  output logic                  run,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow,
  output logic [31:0]           checksum
);

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  state_t                  state;
  logic [1:0]              byte_idx;
  logic [23:0]             asm_q;      // bytes 0..2 of the word being built
  logic [ADDR_WIDTH-1:0]   wptr;
  logic [DATA_WIDTH-1:0]   mem [0:(1 << ADDR_WIDTH) - 1];

  logic                    accept;
  logic                    full;
  logic                    commit;
  logic [31:0]             word_merged;

  assign in_ready = (state == LOAD);
  assign accept   = in_valid && (state == LOAD);
  assign full     = word_count[ADDR_WIDTH];
  assign commit   = accept && !full && ((byte_idx == 2'd3) || in_last);

  // Current byte merged into the partial word; higher bytes stay zero because
  // asm_q is cleared on every commit, giving the zero padding for short words.
  always_comb begin
    word_merged = '0;
    case (byte_idx)
      2'd0: word_merged = {24'h0, in_data};
      2'd1: word_merged = {16'h0, in_data, asm_q[7:0]};
      2'd2: word_merged = {8'h0, in_data, asm_q[15:0]};
      2'd3: word_merged = {in_data, asm_q};
      default: word_merged = '0;
    endcase
  end

  // Instruction RAM: not cleared by reset.
  always_ff @(posedge clock) begin
    if (commit) begin
      mem[wptr] <= word_merged;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      run        <= 1'b0;
      byte_idx   <= '0;
      asm_q      <= '0;
      wptr       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (full) begin
              // RAM full: consume and drop the byte so the loader never stalls.
              overflow <= 1'b1;
            end else if (commit) begin
              wptr       <= wptr + 1'b1;
              word_count <= word_count + 1'b1;
              byte_idx   <= '0;
              asm_q      <= '0;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              asm_q    <= word_merged[23:0];
            end
            if (in_last) begin
              state <= RUN;
              run   <= 1'b1;
            end
          end
        end
        RUN: begin
          state <= RUN;
          run   <= 1'b1;
        end
        default: begin
          state <= LOAD;
          run   <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-image reads return sll $0,$0,0 so the core never sees stale words.
  always_comb begin
    instr = '0;
    if ((state == RUN) && (raddr[31:ADDR_WIDTH] == '0) &&
        ({1'b0, raddr[ADDR_WIDTH-1:0]} < word_count)) begin
      instr = mem[raddr[ADDR_WIDTH-1:0]];
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (commit) begin
      checksum_q <= checksum_q + word_merged;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
module tb_imem_stream_loader;

  localparam int AW = 6;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic [31:0]   raddr;
  logic [31:0]   instr;
  logic          run;
  logic [AW:0]   word_count;
  logic          overflow;
  logic [31:0]   checksum;

  int n_vec;
  int n_err;

  imem_stream_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .raddr      (raddr),
    .instr      (instr),
    .run        (run),
    .word_count (word_count),
    .overflow   (overflow),
    .checksum   (checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks run there too.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    check(tag, instr, exp);
  endtask

  function automatic logic [31:0] exp_csum(input logic [31:0] v);
`ifdef IMEM_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  logic [7:0]  img [0:7];
  logic [31:0] sum;
  logic [31:0] w;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    raddr    = '0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    reset    = 1'b0;
    #2;
    do_reset();

    // Reset state
    check("rst_run", {31'h0, run}, 32'h0);
    check("rst_wc", {25'h0, word_count}, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'h0);
    check("rst_ready", {31'h0, in_ready}, 32'h1);
    check("rst_instr", instr, 32'h0);
    check("rst_csum", checksum, 32'h0);

    // Single word image
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h4b, 1'b0);
    check("t1_run_before_last", {31'h0, run}, 32'h0);
    send_byte(8'h11, 1'b1);
    check("t1_wc", {25'h0, word_count}, 32'h1);
    check("t1_run", {31'h0, run}, 32'h1);
    check("t1_ready", {31'h0, in_ready}, 32'h0);
    read_chk("t1_rd0", 32'd0, 32'h114b0001);
    read_chk("t1_rd1", 32'd1, 32'h0);

    // Five-byte image with zero-padded tail word
    do_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b1);
    check("t2_wc", {25'h0, word_count}, 32'h2);
    read_chk("t2_rd0", 32'd0, 32'hDDCCBBAA);
    read_chk("t2_rd1", 32'd1, 32'h000000EE);
    read_chk("t2_rd2", 32'd2, 32'h0);
    check("t2_csum", checksum, exp_csum(32'hDDCCBC98));

    // Lone in_last byte commits a one-word image
    do_reset();
    send_byte(8'h5A, 1'b1);
    check("t3_wc", {25'h0, word_count}, 32'h1);
    read_chk("t3_rd0", 32'd0, 32'h0000005A);

    // Stalled 8-byte image: valid pattern 1,0,0,1 repeating
    do_reset();
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    img[4] = 8'h55; img[5] = 8'h66; img[6] = 8'h77; img[7] = 8'h88;
    raddr = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) begin
        // two idle cycles before every other byte
        repeat (2) begin
          check("t4_ready_idle", {31'h0, in_ready}, 32'h1);
          @(posedge clock);
          #1;
        end
      end
      check("t4_ready", {31'h0, in_ready}, 32'h1);
      send_byte(img[i], (i == 7));
      if (i == 4) check("t4_instr_in_load", instr, 32'h0);
    end
    check("t4_wc", {25'h0, word_count}, 32'h2);
    read_chk("t4_rd0", 32'd0, 32'h44332211);
    read_chk("t4_rd1", 32'd1, 32'h88776655);
    check("t4_csum", checksum, exp_csum(32'h44332211 + 32'h88776655));

    // 260 bytes into a 64-word RAM: overflow on the last word
    do_reset();
    for (int i = 0; i < 260; i++) begin
      if (i == 256) begin
        check("t5_wc_full", {25'h0, word_count}, 32'd64);
        check("t5_ovf_before", {31'h0, overflow}, 32'h0);
        check("t5_ready_full", {31'h0, in_ready}, 32'h1);
      end
      send_byte(i[7:0], (i == 259));
    end
    sum = '0;
    for (int k = 0; k < 64; k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      sum = sum + w;
    end
    check("t5_wc", {25'h0, word_count}, 32'd64);
    check("t5_ovf", {31'h0, overflow}, 32'h1);
    check("t5_run", {31'h0, run}, 32'h1);
    read_chk("t5_rd0", 32'd0, 32'h03020100);
    read_chk("t5_rd63", 32'd63, 32'hFFFEFDFC);
    read_chk("t5_rd64", 32'd64, 32'h0);
    check("t5_csum", checksum, exp_csum(sum));

    // Reset in the middle of a load, then a fresh image
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i), 1'b0);
    reset = 1'b1;
    #1;
    check("t6_run", {31'h0, run}, 32'h0);
    check("t6_wc", {25'h0, word_count}, 32'h0);
    read_chk("t6_instr", 32'd0, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    send_byte(8'h0D, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    check("t6_run_after", {31'h0, run}, 32'h1);
    read_chk("t6_rd0", 32'd0, 32'h0000000D);
    check("t6_csum", checksum, exp_csum(32'h0000000D));

    // Stream traffic is ignored in RUN
    raddr    = 32'd0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      check("t7_ready", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    check("t7_wc", {25'h0, word_count}, 32'h1);
    read_chk("t7_rd0", 32'd0, 32'h0000000D);
    read_chk("t7_rd40", 32'h00000040, 32'h0);
    read_chk("t7_rdhi", 32'h10000000, 32'h0);
    check("t7_csum", checksum, exp_csum(32'h0000000D));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
